// File: rtl/fifo_sdpram_param_if.sv
// CSR-side and consumer-side signals of fifo_sdpram_param grouped as one bus.
// FIFO_STATUS_CSR_EN adds the csr_read_en strobe for the status read word.
interface fifo_sdpram_param_if #(
  parameter int unsigned DataWidth = 8
);
  logic                 csr_enable;
  logic [11:0]          csr_addr;
  logic [31:0]          rs1_data;
`ifdef FIFO_STATUS_CSR_EN
  logic                 csr_read_en;
`endif
  logic                 next;
  logic [DataWidth-1:0] data;
  logic                 have_next;
  logic [31:0]          csr_data_out;

  modport master (
`ifdef FIFO_STATUS_CSR_EN
    output csr_read_en,
`endif
    output csr_enable, csr_addr, rs1_data, next,
    input  data, have_next, csr_data_out
  );

  modport slave (
`ifdef FIFO_STATUS_CSR_EN
    input  csr_read_en,
`endif
    input  csr_enable, csr_addr, rs1_data, next,
    output data, have_next, csr_data_out
  );
endinterface

// File: rtl/fifo_sdpram_param.sv
// CSR-fed FIFO on a simple dual-port RAM with registered read and show-ahead head.
// Optional status read word enabled by the FIFO_STATUS_CSR_EN macro.
module fifo_sdpram_param #(
  parameter int unsigned DataWidth       = 8,
  parameter int unsigned DepthLog2       = 4,
  parameter int unsigned AlmostFullLevel = 12,
  parameter logic [11:0] PushCsrAddr     = 12'h7C0,
  parameter logic [11:0] CtrlCsrAddr     = 12'h7C1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  fifo_sdpram_param_if.slave   bus,
  output logic [DepthLog2:0]   count,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow
);

  localparam int unsigned Depth = 1 << DepthLog2;

  typedef logic [DepthLog2-1:0] ptr_t;
  typedef logic [DepthLog2:0]   cnt_t;

  logic [DataWidth-1:0] mem [Depth];
  logic [DataWidth-1:0] ram_q;
  logic [DataWidth-1:0] byp_q;
  logic                 sel_byp_q, sel_byp_d;
  logic                 have_next_q, have_next_d;
  logic                 load_byp;
  ptr_t                 rd_ptr_q, rd_ptr_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  cnt_t                 count_d;
  logic                 overflow_d;

  logic push_req, ctrl_wr, flush, ovf_clr, pop, push_acc, wr_en;
  logic unused_rs1;

  assign push_req = bus.csr_enable && (bus.csr_addr == PushCsrAddr);
  assign ctrl_wr  = bus.csr_enable && (bus.csr_addr == CtrlCsrAddr);
  assign flush    = ctrl_wr && bus.rs1_data[0];
  assign ovf_clr  = ctrl_wr && bus.rs1_data[1];
  assign pop      = bus.next && have_next_q;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_acc = push_req && (!full || pop);
  assign wr_en    = push_acc && !flush;
  assign unused_rs1 = ^bus.rs1_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count;
    have_next_d = have_next_q;
    sel_byp_d   = sel_byp_q;
    load_byp    = 1'b0;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      have_next_d = 1'b0;
    end else begin
      if (pop)      rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      count_d     = count + cnt_t'(push_acc) - cnt_t'(pop);
      have_next_d = (count_d != '0);
      // The new head is written this very edge: the RAM cannot return it yet.
      if (push_acc && ((count == '0) || ((count == cnt_t'(1)) && pop))) begin
        sel_byp_d = 1'b1;
        load_byp  = 1'b1;
      end else if (pop) begin
        sel_byp_d = 1'b0;
      end
    end
  end

  assign overflow_d = (overflow && !ovf_clr) || (push_req && full && !pop && !flush);

  // NOTE: RAM storage and its read register carry no reset; pointers and count
  // define which words are meaningful, so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= bus.rs1_data[DataWidth-1:0];
    ram_q <= mem[rd_ptr_d];
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      have_next_q <= 1'b0;
      sel_byp_q   <= 1'b0;
      byp_q       <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count       <= count_d;
      full        <= (count_d == cnt_t'(Depth));
      almost_full <= (count_d >= cnt_t'(AlmostFullLevel));
      overflow    <= overflow_d;
      have_next_q <= have_next_d;
      sel_byp_q   <= sel_byp_d;
      if (load_byp) byp_q <= bus.rs1_data[DataWidth-1:0];
    end
  end

  assign bus.have_next = have_next_q;
  assign bus.data      = have_next_q ? (sel_byp_q ? byp_q : ram_q) : '0;

`ifdef FIFO_STATUS_CSR_EN
  logic [31:0] csr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csr_q <= '0;
    end else if (bus.csr_read_en && (bus.csr_addr == CtrlCsrAddr)) begin
      csr_q <= {13'b0, almost_full, full, overflow, 16'(count)};
    end else begin
      csr_q <= '0;
    end
  end

  assign bus.csr_data_out = csr_q;
`else
  assign bus.csr_data_out = '0;
`endif

endmodule
